// File: rtl/pc_pkg.sv
// Shared definitions for the multi-lane password cracker: character-set size,
// symbol-to-ASCII mapping and FSM states. PC_LOWERCASE_EN adds 'a'-'z' to the set.
package pc_pkg;

`ifdef PC_LOWERCASE_EN
    localparam int CHARSET_SIZE = 62;
`else
    localparam int CHARSET_SIZE = 36;
`endif

    localparam int SYM_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Symbol order: '0'-'9', 'A'-'Z', then 'a'-'z' when enabled.
    function automatic logic [7:0] sym_to_ascii(input logic [SYM_W-1:0] s);
        if (s < 6'd10) begin
            return 8'd48 + {2'b00, s};
        end else if (s < 6'd36) begin
            return 8'd55 + {2'b00, s};
        end else begin
            return 8'd61 + {2'b00, s};
        end
    endfunction

endpackage

// File: rtl/pc_lane.sv
// One search lane: mixed-radix candidate counter over first-symbol range [LO, HI],
// ASCII compare against the target, and match/exhausted status.
module pc_lane
    import pc_pkg::*;
#(
    parameter int PW_LEN = 4,
    parameter int LO     = 0,
    parameter int HI     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                run_i,
    input  logic [PW_LEN*8-1:0] target_i,
    output logic [PW_LEN*8-1:0] cand_o,
    output logic                match_o,
    output logic                exhausted_o
);
    localparam bit              EMPTY   = (LO > HI);
    localparam logic [SYM_W-1:0] LO_SYM  = EMPTY ? '0 : SYM_W'(LO);
    localparam logic [SYM_W-1:0] HI_SYM  = EMPTY ? '0 : SYM_W'(HI);
    localparam logic [SYM_W-1:0] MAX_SYM = SYM_W'(CHARSET_SIZE - 1);

    logic [PW_LEN-1:0][SYM_W-1:0] sym_q, sym_d;
    logic                         active_q, active_d;
    logic                         at_last;
    logic                         carry;

    always_comb begin
        at_last = (sym_q[PW_LEN-1] == HI_SYM);
        for (int j = 0; j < PW_LEN - 1; j++) begin
            if (sym_q[j] != MAX_SYM) at_last = 1'b0;
        end
    end

    always_comb begin
        cand_o = '0;
        for (int j = 0; j < PW_LEN; j++) begin
            cand_o[j*8 +: 8] = sym_to_ascii(sym_q[j]);
        end
    end

    // exhausted_o also covers the edge on which the final candidate is compared.
    assign match_o     = active_q && (cand_o == target_i);
    assign exhausted_o = !active_q || at_last;

    always_comb begin
        sym_d    = sym_q;
        active_d = active_q;
        carry    = 1'b0;
        if (load_i) begin
            sym_d           = '0;
            sym_d[PW_LEN-1] = LO_SYM;
            active_d        = !EMPTY;
        end else if (run_i && active_q) begin
            if (at_last) begin
                active_d = 1'b0;
            end else begin
                carry = 1'b1;
                for (int j = 0; j < PW_LEN; j++) begin
                    if (carry) begin
                        if (sym_q[j] == MAX_SYM) begin
                            sym_d[j] = '0;
                        end else begin
                            sym_d[j] = sym_q[j] + 1'b1;
                            carry    = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) active_q <= 1'b0;
        else     active_q <= active_d;
    end

    always_ff @(posedge clk) begin
        sym_q <= sym_d;
    end

endmodule

// File: rtl/password_cracker_multi.sv
// Multi-lane brute-force password cracker top: start/abort FSM, lane priority
// encoder, result registers and saturating cycle counter. Option: PC_LOWERCASE_EN.
module password_cracker_multi
    import pc_pkg::*;
#(
    parameter int PW_LEN = 4,
    parameter int LANES  = 9,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PW_LEN*8-1:0] password_to_crack,
    output logic                busy,
    output logic                found,
    output logic                done,
    output logic [PW_LEN*8-1:0] found_password,
    output logic [CNT_W-1:0]    cycles
);
    localparam int CHUNK = (CHARSET_SIZE + LANES - 1) / LANES;

    state_e              state_q, state_d;
    logic                found_q, found_d;
    logic                done_q, done_d;
    logic [PW_LEN*8-1:0] fpw_q, fpw_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [PW_LEN*8-1:0] target_q;

    logic                load;
    logic                running;
    logic [LANES-1:0]    match;
    logic [LANES-1:0]    exhausted;
    logic [PW_LEN*8-1:0] cand [LANES];
    logic                hit;
    logic [PW_LEN*8-1:0] win_pw;

    assign running = (state_q == RUN);
    assign load    = start && ((state_q == IDLE) || (state_q == DONE));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int LO = i * CHUNK;
        localparam int HI = (((i + 1) * CHUNK < CHARSET_SIZE) ? (i + 1) * CHUNK : CHARSET_SIZE) - 1;
        pc_lane #(
            .PW_LEN(PW_LEN),
            .LO    (LO),
            .HI    (HI)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load),
            .run_i      (running),
            .target_i   (target_q),
            .cand_o     (cand[i]),
            .match_o    (match[i]),
            .exhausted_o(exhausted[i])
        );
    end

    // Lowest-index matching lane wins.
    always_comb begin
        hit    = 1'b0;
        win_pw = '0;
        for (int i = 0; i < LANES; i++) begin
            if (match[i] && !hit) begin
                hit    = 1'b1;
                win_pw = cand[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        found_d = found_q;
        done_d  = done_q;
        fpw_d   = fpw_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    found_d = 1'b0;
                    done_d  = 1'b0;
                    fpw_d   = '0;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (hit) begin
                    state_d = DONE;
                    found_d = 1'b1;
                    done_d  = 1'b1;
                    fpw_d   = win_pw;
                end else if (&exhausted) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            found_q <= 1'b0;
            done_q  <= 1'b0;
            fpw_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            found_q <= found_d;
            done_q  <= done_d;
            fpw_q   <= fpw_d;
            cyc_q   <= cyc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) target_q <= password_to_crack;
    end

    assign busy           = running;
    assign found          = found_q;
    assign done           = done_q;
    assign found_password = fpw_q;
    assign cycles         = cyc_q;

endmodule

// File: tb/tb_password_cracker_multi.sv
// Bench for password_cracker_multi: one PW_LEN=4 instance plus three PW_LEN=2
// instances (LANES 9, 5, 36) checked against a keyspace-arithmetic reference model.
module tb_password_cracker_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, abort0 = 1'b0;
    logic [31:0] pw0 = '0;
    logic        busy0, found0, done0;
    logic [31:0] fpw0, cyc0;

    logic        start2 = 1'b0, abort2 = 1'b0;
    logic [15:0] pw2 = '0;
    logic        busy2 [3];
    logic        found2 [3];
    logic        done2 [3];
    logic [15:0] fpw2 [3];
    logic [31:0] cyc2 [3];

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef PC_LOWERCASE_EN
    string CS = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";
`else
    string CS = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZ";
`endif
    localparam int LN [3] = '{9, 5, 36};

    password_cracker_multi #(.PW_LEN(4), .LANES(9), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .password_to_crack(pw0), .busy(busy0), .found(found0), .done(done0),
        .found_password(fpw0), .cycles(cyc0)
    );

    for (genvar g = 0; g < 3; g++) begin : g_dut2
        password_cracker_multi #(.PW_LEN(2), .LANES(LN[g]), .CNT_W(32)) dut (
            .clk(clk), .rst(rst), .start(start2), .abort(abort2),
            .password_to_crack(pw2), .busy(busy2[g]), .found(found2[g]), .done(done2[g]),
            .found_password(fpw2[g]), .cycles(cyc2[g])
        );
    end

    typedef struct packed {
        logic [15:0]      tgt;
        logic [2:0]       ef;
        logic [2:0][31:0] ec;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sym_of(input logic [7:0] c);
        for (int i = 0; i < CS.len(); i++) if (CS[i] == c) return i;
        return -1;
    endfunction

    // Lane owning the first symbol reaches the target after (offset within its slice)+1 edges.
    function automatic void model(input logic [31:0] tgt, input int len, input int lanes,
                                  output bit f, output longint cyc);
        int     n = CS.len();
        int     chunk = (n + lanes - 1) / lanes;
        longint span = 1;
        longint rest = 0;
        int     s0 = 0;
        bit     ok = 1'b1;
        for (int j = 1; j < len; j++) span *= n;
        for (int j = 0; j < len; j++) begin
            int s;
            s = sym_of(tgt[(len-1-j)*8 +: 8]);
            if (s < 0) ok = 1'b0;
            else if (j == 0) s0 = s;
            else rest = rest * n + s;
        end
        if (!ok) begin
            f = 1'b0;
            cyc = chunk * span;
        end else begin
            f = 1'b1;
            cyc = (s0 % chunk) * span + rest + 1;
        end
    endfunction

    task automatic add_vec(input logic [15:0] t, input bit f9, input bit f5, input bit f36,
                           input int c9, input int c5, input int c36);
        vec_t v;
        v.tgt = t;
        v.ef  = {f36, f5, f9};
        v.ec[0] = c9;
        v.ec[1] = c5;
        v.ec[2] = c36;
        tbl.push_back(v);
    endtask

    task automatic run2(input logic [15:0] tgt, input logic [2:0] ef,
                        input logic [2:0][31:0] ec, input string tag);
        int n;
        @(negedge clk);
        pw2 = tgt;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int g = 0; g < 3; g++) check($sformatf("%s L%0d busy", tag, LN[g]), busy2[g], 1);
        n = 0;
        while (n < 2000 && !(done2[0] && done2[1] && done2[2])) begin
            @(negedge clk);
            n++;
        end
        check({tag, " timeout"}, n < 2000, 1);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s L%0d found", tag, LN[g]), found2[g], ef[g]);
            check($sformatf("%s L%0d done", tag, LN[g]), done2[g], 1);
            check($sformatf("%s L%0d busy_end", tag, LN[g]), busy2[g], 0);
            check($sformatf("%s L%0d fpw", tag, LN[g]), fpw2[g], ef[g] ? tgt : 16'h0);
            check($sformatf("%s L%0d cycles", tag, LN[g]), cyc2[g], ec[g]);
        end
    endtask

    task automatic start_dut0(input logic [31:0] tgt);
        @(negedge clk);
        pw0 = tgt;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_dut0(input string tag);
        int n = 0;
        while (n < 1000 && !done0) begin
            @(negedge clk);
            n++;
        end
        check({tag, " timeout"}, n < 1000, 1);
    endtask

    task automatic expect_dut0(input string tag, input logic [31:0] tgt);
        bit     f;
        longint c;
        model(tgt, 4, 9, f, c);
        check({tag, " found"}, found0, f);
        check({tag, " done"}, done0, 1);
        check({tag, " busy"}, busy0, 0);
        check({tag, " fpw"}, fpw0, f ? tgt : 32'h0);
        check({tag, " cycles"}, cyc0, c);
    endtask

    initial begin
`ifdef PC_LOWERCASE_EN
        add_vec("00", 1, 1, 1, 1, 1, 1);
        add_vec("Z0", 1, 1, 1, 1, 559, 63);
        add_vec("ZZ", 1, 1, 1, 36, 594, 98);
        add_vec("!!", 0, 0, 0, 434, 806, 124);
        add_vec("az", 1, 1, 1, 124, 682, 62);
`else
        add_vec("00", 1, 1, 1, 1, 1, 1);
        add_vec("Z0", 1, 1, 1, 109, 109, 1);
        add_vec("ZZ", 1, 1, 1, 144, 144, 36);
        add_vec("!!", 0, 0, 0, 144, 288, 36);
        add_vec("az", 0, 0, 0, 144, 288, 36);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst busy", busy0, 0);
        check("rst found", found0, 0);
        check("rst done", done0, 0);
        check("rst fpw", fpw0, 0);
        check("rst cycles", cyc0, 0);
        check("rst L5 busy", busy2[1], 0);

        // Basic find, cycles = k+1
        start_dut0("0001");
        check("0001 busy_e0", busy0, 1);
        check("0001 done_e0", done0, 0);
        wait_dut0("0001");
        expect_dut0("0001", "0001");

        // Abort together with start on the 10th RUN edge
        start_dut0("ZZZZ");
        repeat (9) @(negedge clk);
        abort0 = 1'b1;
        start0 = 1'b1;
        pw0 = "0000";
        @(negedge clk);
        abort0 = 1'b0;
        start0 = 1'b0;
        check("abort busy", busy0, 0);
        check("abort found", found0, 0);
        check("abort done", done0, 0);
        check("abort cycles", cyc0, 10);
        abort0 = 1'b1;
        repeat (3) @(negedge clk);
        abort0 = 1'b0;
        check("idle_abort busy", busy0, 0);
        check("idle_abort cycles", cyc0, 10);
        check("idle_abort done", done0, 0);

        // Start during RUN is ignored
        start_dut0("0005");
        @(negedge clk);
        pw0 = "0009";
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_dut0("ign_start");
        expect_dut0("ign_start", "0005");

        // Restart from DONE
        start_dut0("00A0");
        wait_dut0("00A0");
        expect_dut0("00A0", "00A0");

        // Async reset while in DONE
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_done found", found0, 0);
        check("rst_done done", done0, 0);
        check("rst_done fpw", fpw0, 0);
        check("rst_done cycles", cyc0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-search, then a fresh search
        start_dut0("ZZZZ");
        repeat (5) @(negedge clk);
        check("mid busy", busy0, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid busy", busy0, 0);
        check("rst_mid cycles", cyc0, 0);
        check("rst_mid done", done0, 0);
        @(negedge clk);
        rst = 1'b0;
        start_dut0("0001");
        wait_dut0("post_rst");
        expect_dut0("post_rst", "0001");

        // Table vectors on the PW_LEN=2 instances
        foreach (tbl[i]) run2(tbl[i].tgt, tbl[i].ef, tbl[i].ec, $sformatf("tbl%0d", i));

        // Random PW_LEN=2 targets against the reference model
        for (int it = 0; it < 20; it++) begin
            logic [15:0]      t;
            logic [2:0]       ef;
            logic [2:0][31:0] ec;
            bit               f;
            longint           c;
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 9) == 0) t[b*8 +: 8] = 8'($urandom_range(0, 255));
                else t[b*8 +: 8] = CS[$urandom_range(0, CS.len() - 1)];
            end
            for (int g = 0; g < 3; g++) begin
                model({16'h0, t}, 2, LN[g], f, c);
                ef[g] = f;
                ec[g] = 32'(c);
            end
            run2(t, ef, ec, $sformatf("rnd%0d", it));
        end

        // Random PW_LEN=4 targets near each lane's start
        for (int it = 0; it < 10; it++) begin
            int          chunk;
            int          s0;
            logic [31:0] t;
            chunk = (CS.len() + 8) / 9;
            s0 = $urandom_range(0, 8) * chunk;
            t = {CS[s0], CS[0], CS[$urandom_range(0, 4)], CS[$urandom_range(0, CS.len() - 1)]};
            start_dut0(t);
            wait_dut0($sformatf("r4_%0d", it));
            expect_dut0($sformatf("r4_%0d", it), t);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
